// File: rtl/sys_cmd_master.sv
// Host-side command initiator: serialises one command into a UART byte frame, then collects
// the 0/1/2-byte response and reports it as a word with valid/error pulses.
module sys_cmd_master #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR          = 4,
    parameter int unsigned ALU_OUT_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYC   = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Cmd_Valid,
    input  logic [1:0]               Cmd_Type,
    input  logic [ADDR-1:0]          Cmd_Addr,
    input  logic [DATA_WIDTH-1:0]    Cmd_OpA,
    input  logic [DATA_WIDTH-1:0]    Cmd_OpB,
    input  logic [3:0]               Cmd_Fun,
    output logic                     Cmd_Ready,
    input  logic                     TX_Busy,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RX_P_Data,
    input  logic                     RX_D_VLD,
    output logic [ALU_OUT_WIDTH-1:0] Resp_Data,
    output logic                     Resp_Valid,
    output logic                     Resp_Err
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);
    localparam int unsigned HiW = ALU_OUT_WIDTH - DATA_WIDTH;

    localparam logic [1:0] TypeWr     = 2'd0;
    localparam logic [1:0] TypeRd     = 2'd1;
    localparam logic [1:0] TypeAluOp  = 2'd2;
    localparam logic [1:0] TypeAluNop = 2'd3;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e                   r_state;
    logic [1:0]               r_type;
    logic [ADDR-1:0]          r_addr;
    logic [DATA_WIDTH-1:0]    r_opa;
    logic [DATA_WIDTH-1:0]    r_opb;
    logic [3:0]               r_fun;
    logic [1:0]               r_idx;
    logic                     r_rx_idx;
    logic [CntW-1:0]          r_cnt;
    logic [ALU_OUT_WIDTH-1:0] r_resp_data;
    logic                     r_resp_valid;
    logic                     r_resp_err;

    logic [DATA_WIDTH-1:0]    w_frame_byte;
    logic [1:0]               w_last_idx;
    logic                     w_last_rx;
    logic                     w_tx_fire;

    // Frame byte selected by the latched command type and the byte index
    always_comb begin
        w_frame_byte = '0;
        w_last_idx   = 2'd1;
        w_last_rx    = 1'b1;
        unique case (r_type)
            TypeWr: begin
                w_last_idx = 2'd2;
                unique case (r_idx)
                    2'd0:    w_frame_byte = DATA_WIDTH'(8'hAA);
                    2'd1:    w_frame_byte = DATA_WIDTH'(r_addr);
                    default: w_frame_byte = r_opa;
                endcase
            end
            TypeRd: begin
                w_last_rx    = 1'b0;
                w_frame_byte = (r_idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(r_addr);
            end
            TypeAluOp: begin
                w_last_idx = 2'd3;
                unique case (r_idx)
                    2'd0:    w_frame_byte = DATA_WIDTH'(8'hCC);
                    2'd1:    w_frame_byte = r_opa;
                    2'd2:    w_frame_byte = r_opb;
                    default: w_frame_byte = DATA_WIDTH'(r_fun);
                endcase
            end
            TypeAluNop: begin
                w_frame_byte = (r_idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(r_fun);
            end
            default: w_frame_byte = '0;
        endcase
    end

    assign w_tx_fire  = (r_state == StSend) && !TX_Busy;
    assign Cmd_Ready  = (r_state == StIdle);
    assign TX_D_VLD   = w_tx_fire;
    assign TX_P_DATA  = w_tx_fire ? w_frame_byte : '0;
    assign Resp_Data  = r_resp_data;
    assign Resp_Valid = r_resp_valid;
    assign Resp_Err   = r_resp_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= StIdle;
            r_type       <= '0;
            r_addr       <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_fun        <= '0;
            r_idx        <= '0;
            r_rx_idx     <= 1'b0;
            r_cnt        <= '0;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (Cmd_Valid) begin
                        r_type  <= Cmd_Type;
                        r_addr  <= Cmd_Addr;
                        r_opa   <= Cmd_OpA;
                        r_opb   <= Cmd_OpB;
                        r_fun   <= Cmd_Fun;
                        r_idx   <= '0;
                        r_state <= StSend;
                    end
                end
                StSend: begin
                    if (w_tx_fire) begin
                        if (r_idx == w_last_idx) begin
                            r_idx <= '0;
                            if (r_type == TypeWr) begin
                                r_state <= StIdle;
                            end else begin
                                r_state  <= StWait;
                                r_cnt    <= '0;
                                r_rx_idx <= 1'b0;
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                StWait: begin
                    // A byte arriving on the limit cycle takes priority over the timeout
                    if (RX_D_VLD) begin
                        r_cnt <= '0;
                        if (!r_rx_idx) begin
                            r_resp_data <= ALU_OUT_WIDTH'(RX_P_Data);
                        end else begin
                            r_resp_data[ALU_OUT_WIDTH-1:DATA_WIDTH] <= HiW'(RX_P_Data);
                        end
                        if (r_rx_idx == w_last_rx) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= StDone;
                        end else begin
                            r_rx_idx <= 1'b1;
                        end
                    end else if (r_cnt == CntMax) begin
                        r_resp_err <= 1'b1;
                        r_state    <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StDone: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cmd_master.sv
// Directed bench for sys_cmd_master: frames, responses, TX stalls, timeout edge and reset.
module tb_sys_cmd_master;

    logic        CLK;
    logic        RST;
    logic        Cmd_Valid;
    logic [1:0]  Cmd_Type;
    logic [3:0]  Cmd_Addr;
    logic [7:0]  Cmd_OpA;
    logic [7:0]  Cmd_OpB;
    logic [3:0]  Cmd_Fun;
    logic        Cmd_Ready;
    logic        TX_Busy;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic [7:0]  RX_P_Data;
    logic        RX_D_VLD;
    logic [15:0] Resp_Data;
    logic        Resp_Valid;
    logic        Resp_Err;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;

    sys_cmd_master #(
        .DATA_WIDTH    (8),
        .ADDR          (4),
        .ALU_OUT_WIDTH (16),
        .TIMEOUT_CYC   (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Cmd_Valid  (Cmd_Valid),
        .Cmd_Type   (Cmd_Type),
        .Cmd_Addr   (Cmd_Addr),
        .Cmd_OpA    (Cmd_OpA),
        .Cmd_OpB    (Cmd_OpB),
        .Cmd_Fun    (Cmd_Fun),
        .Cmd_Ready  (Cmd_Ready),
        .TX_Busy    (TX_Busy),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .RX_P_Data  (RX_P_Data),
        .RX_D_VLD   (RX_D_VLD),
        .Resp_Data  (Resp_Data),
        .Resp_Valid (Resp_Valid),
        .Resp_Err   (Resp_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (Resp_Valid === 1'b1) n_valid <= n_valid + 1;
        if (Resp_Err === 1'b1) n_err <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    // Present a command for one cycle; returns in the first SEND cycle
    task automatic accept(input string tag, input logic [1:0] t, input logic [3:0] a,
                          input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
        cyc();
        Cmd_Valid = 1'b1;
        Cmd_Type  = t;
        Cmd_Addr  = a;
        Cmd_OpA   = oa;
        Cmd_OpB   = ob;
        Cmd_Fun   = f;
        #1;
        chk({tag, "_ready"}, 32'(Cmd_Ready), 32'd1);
        cyc();
        Cmd_Valid = 1'b0;
    endtask

    // Check the byte driven this cycle, then advance one cycle
    task automatic txb(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, 32'(TX_D_VLD), 32'd1);
        chk({tag, "_data"}, 32'(TX_P_DATA), 32'(exp));
        chk({tag, "_busy_ready"}, 32'(Cmd_Ready), 32'd0);
        cyc();
    endtask

    initial begin
        RST       = 1'b0;
        Cmd_Valid = 1'b0;
        Cmd_Type  = 2'd0;
        Cmd_Addr  = 4'd0;
        Cmd_OpA   = 8'd0;
        Cmd_OpB   = 8'd0;
        Cmd_Fun   = 4'd0;
        TX_Busy   = 1'b0;
        RX_P_Data = 8'd0;
        RX_D_VLD  = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", 32'(Cmd_Ready), 32'd1);
        chk("rst_txvld", 32'(TX_D_VLD), 32'd0);
        chk("rst_txdata", 32'(TX_P_DATA), 32'd0);
        chk("rst_rvalid", 32'(Resp_Valid), 32'd0);
        chk("rst_rerr", 32'(Resp_Err), 32'd0);
        chk("rst_rdata", 32'(Resp_Data), 32'd0);
        RST = 1'b1;

        // T1 register write: AA 05 3C back-to-back, no response
        accept("t1", 2'd0, 4'd5, 8'h3C, 8'h00, 4'd0);
        txb("t1_b0", 8'hAA);
        txb("t1_b1", 8'h05);
        txb("t1_b2", 8'h3C);
        chk("t1_ready_back", 32'(Cmd_Ready), 32'd1);
        chk("t1_idle_vld", 32'(TX_D_VLD), 32'd0);
        chk("t1_no_rvalid", 32'(Resp_Valid), 32'd0);

        // T2 register read: BB 02, one response byte
        accept("t2", 2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
        txb("t2_b0", 8'hBB);
        txb("t2_b1", 8'h02);
        RX_D_VLD  = 1'b1;
        RX_P_Data = 8'h9A;
        cyc();
        RX_D_VLD = 1'b0;
        chk("t2_rvalid", 32'(Resp_Valid), 32'd1);
        chk("t2_rdata", 32'(Resp_Data), 32'h009A);
        chk("t2_ready_done", 32'(Cmd_Ready), 32'd0);
        cyc();
        chk("t2_rvalid_off", 32'(Resp_Valid), 32'd0);
        chk("t2_ready_back", 32'(Cmd_Ready), 32'd1);

        // T3 ALU op with TX stalls: CC 0A 03 02, response 1E 00
        accept("t3", 2'd2, 4'd0, 8'h0A, 8'h03, 4'd2);
        txb("t3_b0", 8'hCC);
        TX_Busy = 1'b1;
        #1;
        chk("t3_stall1_vld", 32'(TX_D_VLD), 32'd0);
        chk("t3_stall1_data", 32'(TX_P_DATA), 32'd0);
        cyc();
        TX_Busy = 1'b0;
        #1;
        txb("t3_b1", 8'h0A);
        TX_Busy = 1'b1;
        #1;
        chk("t3_stall2_vld", 32'(TX_D_VLD), 32'd0);
        cyc();
        TX_Busy = 1'b0;
        #1;
        txb("t3_b2", 8'h03);
        txb("t3_b3", 8'h02);
        RX_D_VLD  = 1'b1;
        RX_P_Data = 8'h1E;
        cyc();
        RX_P_Data = 8'h00;
        #1;
        chk("t3_no_early_valid", 32'(Resp_Valid), 32'd0);
        cyc();
        RX_D_VLD = 1'b0;
        chk("t3_rvalid", 32'(Resp_Valid), 32'd1);
        chk("t3_rdata", 32'(Resp_Data), 32'h001E);
        cyc();
        // Stray RX byte while idle
        RX_D_VLD  = 1'b1;
        RX_P_Data = 8'h55;
        cyc();
        RX_D_VLD = 1'b0;
        chk("t5_stray_ready", 32'(Cmd_Ready), 32'd1);
        chk("t5_stray_rvalid", 32'(Resp_Valid), 32'd0);
        chk("t5_stray_rdata", 32'(Resp_Data), 32'h001E);

        // T4 timeout: DD 05 with no response
        accept("t4", 2'd3, 4'd0, 8'h00, 8'h00, 4'd5);
        txb("t4_b0", 8'hDD);
        txb("t4_b1", 8'h05);
        repeat (15) cyc();
        chk("t4_no_early_err", 32'(Resp_Err), 32'd0);
        chk("t4_still_busy", 32'(Cmd_Ready), 32'd0);
        cyc();
        chk("t4_err", 32'(Resp_Err), 32'd1);
        chk("t4_ready_back", 32'(Cmd_Ready), 32'd1);
        chk("t4_no_rvalid", 32'(Resp_Valid), 32'd0);
        chk("t4_rdata_kept", 32'(Resp_Data), 32'h001E);
        cyc();
        chk("t4_err_off", 32'(Resp_Err), 32'd0);

        // T5 response byte on the final timeout cycle wins
        accept("t5", 2'd1, 4'd3, 8'h00, 8'h00, 4'd0);
        txb("t5_b0", 8'hBB);
        txb("t5_b1", 8'h03);
        repeat (15) cyc();
        RX_D_VLD  = 1'b1;
        RX_P_Data = 8'h77;
        cyc();
        RX_D_VLD = 1'b0;
        chk("t5_rvalid", 32'(Resp_Valid), 32'd1);
        chk("t5_no_err", 32'(Resp_Err), 32'd0);
        chk("t5_rdata", 32'(Resp_Data), 32'h0077);
        cyc();
        chk("t5_no_late_err", 32'(Resp_Err), 32'd0);

        // T6 reset after the second byte of a CC frame
        accept("t6", 2'd2, 4'd0, 8'hA1, 8'hB2, 4'd7);
        txb("t6_b0", 8'hCC);
        txb("t6_b1", 8'hA1);
        RST = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(Cmd_Ready), 32'd1);
        chk("t6_rst_txvld", 32'(TX_D_VLD), 32'd0);
        chk("t6_rst_txdata", 32'(TX_P_DATA), 32'd0);
        chk("t6_rst_rvalid", 32'(Resp_Valid), 32'd0);
        chk("t6_rst_rerr", 32'(Resp_Err), 32'd0);
        chk("t6_rst_rdata", 32'(Resp_Data), 32'd0);
        cyc();
        RST = 1'b1;
        accept("t6n", 2'd1, 4'd9, 8'h00, 8'h00, 4'd0);
        txb("t6n_b0", 8'hBB);
        txb("t6n_b1", 8'h09);
        RX_D_VLD  = 1'b1;
        RX_P_Data = 8'h42;
        cyc();
        RX_D_VLD = 1'b0;
        chk("t6n_rvalid", 32'(Resp_Valid), 32'd1);
        chk("t6n_rdata", 32'(Resp_Data), 32'h0042);
        cyc();

        chk("valid_pulses", 32'(n_valid), 32'd4);
        chk("err_pulses", 32'(n_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
